rng_share_ctrl: RTL and testbench
=================================

// Module: rng_share_ctrl
// PURPOSE
//  Owns one Fibonacci LFSR and shares its output stream among NUM_REQ requesters in the NoC
//  traffic-generation path (e.g. destination/inject-delay pickers). It sequences the LFSR
//  (seed load, run/halt, advance-on-consume) and arbitrates round-robin.
//  Each issued word goes to exactly one requester; no word is ever handed out twice.
// PARAMETERS
//  NUM_REQ  4      number of requesters (>=2)
//  DW       8      LFSR/word width
//  TAPS     8'hB8  feedback mask; feedback = ^(lfsr & TAPS)
//  SEED     8'h01  reset seed, also substitute for an all-zero seed load (nonzero)
//  CNT_W    16     width of issued-word counter
// PORTS
//  CLK         in   1        clock, all logic on rising edge
//  RST         in   1        synchronous reset, active-high
//  I_EN        in   1        1 = grants allowed; 0 = LFSR halted, no grants
//  I_SEED_LD   in   1        load I_SEED into LFSR this edge
//  I_SEED      in   DW       seed value
//  I_REQ       in   NUM_REQ  per-requester word request, level
//  O_GNT       out  NUM_REQ  one-hot grant pulse, registered
//  O_VALID     out  1        = |O_GNT
//  O_DATA      out  DW       random word for granted requester, valid while O_VALID
//  O_STATE     out  2        FSM state: 0 IDLE, 1 RUN, 2 LOAD
//  O_WORD_CNT  out  CNT_W    words issued since reset/seed load, saturating
// BEHAVIOUR
//  Reset (RST=1 at edge): lfsr=SEED, rr pointer=0, state=IDLE, O_GNT=0, O_VALID=0,
//   O_DATA=0, O_WORD_CNT=0. RST overrides all other inputs.
//  LFSR step: lfsr <= {lfsr[DW-2:0], ^(lfsr & TAPS)}; advances only on a grant, one step per grant.
//  FSM (evaluated every edge, I_SEED_LD highest priority):
//   any state & I_SEED_LD -> LOAD; LOAD -> RUN if I_EN else IDLE;
//   IDLE -> RUN if I_EN; RUN -> IDLE if !I_EN; otherwise hold.
//  Seed load edge: lfsr <= (I_SEED==0) ? SEED : I_SEED; rr pointer <= 0; O_WORD_CNT <= 0;
//   no grant registered at this edge even if requests pending.
//  Grant decision at an edge requires: state==RUN, I_EN=1, I_SEED_LD=0, !RST.
//   Effective request eff[i] = I_REQ[i] & ~O_GNT[i] (requester seen with grant high is
//   ignored that cycle, so holding REQ one cycle past grant never double-grants).
//   Winner = first set eff[] bit searching from rr pointer upward, wrapping NUM_REQ-1 -> 0.
//   On winner w: O_GNT <= onehot(w), O_DATA <= current lfsr, lfsr steps,
//   rr pointer <= (w+1) mod NUM_REQ, O_WORD_CNT += 1 (holds at all-ones).
//   No winner: O_GNT <= 0, O_VALID <= 0, O_DATA holds, lfsr/pointer hold.
//  Latency: I_REQ sampled at edge t -> O_GNT/O_DATA high during cycle after edge t (1 cycle).
//  Throughput: up to 1 grant/cycle total; single requester at most every 2nd cycle.
//  Requester contract: drop I_REQ in the cycle O_GNT[i] is high unless another word wanted.
//  I_EN drop mid-stream: grant already registered completes; none afterwards. LFSR holds.
//  Enable while in LOAD: grants start no earlier than the edge after LOAD->RUN.
//  O_GNT always one-hot or zero; O_VALID == |O_GNT every cycle.
// TESTING
//  Reset with I_REQ=4'hF -> all outputs 0, O_STATE=0; no grant until I_EN=1.
//  I_EN=1, I_REQ=4'b0001 held -> O_DATA sequence 01,02,04,08,11,23 on alternate cycles, O_GNT=0001.
//  I_REQ=4'hF held -> O_GNT 0001,0010,0100,1000,0001 on consecutive cycles, data 01,02,04,08,11.
//  I_SEED_LD with I_SEED=0x00 and requests pending -> no grant that cycle, O_STATE=2, next word 0x01, cnt 0.
//  I_SEED_LD I_SEED=0x5A then single requester -> first O_DATA=0x5A; 255 grants later O_DATA=0x5A again.
//  I_EN dropped while I_REQ=4'hF -> at most one further grant, then O_GNT=0; CNT_W=4: 20 grants -> O_WORD_CNT=0xF.

Source files
------------

// File: rtl/rng_share_ctrl.sv
// rng_share_ctrl: one Fibonacci LFSR shared round-robin among NUM_REQ requesters, one word per grant
module rng_share_ctrl #(
  parameter int              NUM_REQ = 4,
  parameter int              DW      = 8,
  parameter logic [DW-1:0]   TAPS    = 8'hB8,
  parameter logic [DW-1:0]   SEED    = 8'h01,
  parameter int              CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               I_EN,
  input  logic               I_SEED_LD,
  input  logic [DW-1:0]      I_SEED,
  input  logic [NUM_REQ-1:0] I_REQ,
  output logic [NUM_REQ-1:0] O_GNT,
  output logic               O_VALID,
  output logic [DW-1:0]      O_DATA,
  output logic [1:0]         O_STATE,
  output logic [CNT_W-1:0]   O_WORD_CNT
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LOAD = 2'd2} state_t;
  state_t state, state_nxt;
  logic [DW-1:0] lfsr;
  logic [PW-1:0] ptr, win, j;
  logic [NUM_REQ-1:0] eff;
  logic go, hit;
  always_comb begin
    state_nxt = I_SEED_LD ? LOAD : I_EN ? RUN : IDLE;
    go = state == RUN && I_EN && !I_SEED_LD;
    eff = I_REQ & ~O_GNT;
    hit = 1'b0;
    win = ptr;
    j = '0;
    // descending scan so the candidate closest to ptr overwrites the others
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = PW'((int'(ptr) + k) % NUM_REQ);
      if (eff[j]) begin
        hit = 1'b1;
        win = j;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      lfsr <= SEED;
      ptr <= '0;
      O_GNT <= '0;
      O_DATA <= '0;
      O_WORD_CNT <= '0;
    end else begin
      state <= state_nxt;
      if (I_SEED_LD) begin
        lfsr <= I_SEED == '0 ? SEED : I_SEED;
        ptr <= '0;
        O_GNT <= '0;
        O_WORD_CNT <= '0;
      end else if (go && hit) begin
        O_GNT <= NUM_REQ'(1) << win;
        O_DATA <= lfsr;
        lfsr <= {lfsr[DW-2:0], ^(lfsr & TAPS)};
        ptr <= PW'((int'(win) + 1) % NUM_REQ);
        O_WORD_CNT <= &O_WORD_CNT ? O_WORD_CNT : O_WORD_CNT + CNT_W'(1);
      end else begin
        O_GNT <= '0;
      end
    end
  end
  assign O_VALID = |O_GNT;
  assign O_STATE = state;
endmodule

// File: tb/tb_rng_share_ctrl.sv
// tb_rng_share_ctrl: randomized scoreboard bench with a transaction-level reference model
module tb_rng_share_ctrl;
  logic CLK = 1'b0, RST = 1'b1, I_EN = 1'b0, I_SEED_LD = 1'b0;
  logic [7:0] I_SEED = 8'h00;
  logic [3:0] I_REQ = 4'h0;
  logic [3:0] O_GNT, gnt4;
  logic O_VALID, valid4;
  logic [7:0] O_DATA, data4;
  logic [1:0] O_STATE, state4;
  logic [15:0] O_WORD_CNT;
  logic [3:0] cnt4;
  rng_share_ctrl dut (.CLK(CLK), .RST(RST), .I_EN(I_EN), .I_SEED_LD(I_SEED_LD), .I_SEED(I_SEED),
    .I_REQ(I_REQ), .O_GNT(O_GNT), .O_VALID(O_VALID), .O_DATA(O_DATA), .O_STATE(O_STATE),
    .O_WORD_CNT(O_WORD_CNT));
  rng_share_ctrl #(.CNT_W(4)) dut4 (.CLK(CLK), .RST(RST), .I_EN(I_EN), .I_SEED_LD(I_SEED_LD),
    .I_SEED(I_SEED), .I_REQ(I_REQ), .O_GNT(gnt4), .O_VALID(valid4), .O_DATA(data4),
    .O_STATE(state4), .O_WORD_CNT(cnt4));
  always #5 CLK = ~CLK;
  typedef struct {int cyc; logic [3:0] gnt; logic [7:0] data; int cnt; int cnt4;} exp_t;
  exp_t sb[$];
  logic [3:0] obs_g[$];
  logic [7:0] obs_d[$];
  int pass_n = 0, tot_n = 0, cyc = 0;
  int exp_state = 0;
  bit exp_chk = 0;
  logic [7:0] m_lfsr = 8'h01;
  int m_ptr = 0, m_st = 0, m_cnt = 0, m_cnt4 = 0;
  logic [3:0] m_gnt = 4'h0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask
  function automatic logic [7:0] lstep(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction
  // predicts what the upcoming rising edge does with the inputs just driven
  task automatic tick(input bit rst, input bit en, input bit ld, input logic [7:0] seed, input logic [3:0] req);
    int w, idx;
    @(negedge CLK);
    RST = rst; I_EN = en; I_SEED_LD = ld; I_SEED = seed; I_REQ = req;
    if (rst) begin
      m_lfsr = 8'h01; m_ptr = 0; m_st = 0; m_gnt = 0; m_cnt = 0; m_cnt4 = 0;
    end else if (ld) begin
      m_lfsr = seed == 0 ? 8'h01 : seed; m_ptr = 0; m_cnt = 0; m_cnt4 = 0; m_gnt = 0; m_st = 2;
    end else begin
      w = -1;
      if (m_st == 1 && en)
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (w < 0 && req[idx] && !m_gnt[idx]) w = idx;
        end
      if (w >= 0) begin
        m_gnt = 4'(1 << w);
        m_cnt = m_cnt == 65535 ? m_cnt : m_cnt + 1;
        m_cnt4 = m_cnt4 == 15 ? m_cnt4 : m_cnt4 + 1;
        sb.push_back('{cyc + 1, m_gnt, m_lfsr, m_cnt, m_cnt4});
        m_lfsr = lstep(m_lfsr);
        m_ptr = (w + 1) % 4;
      end else m_gnt = 0;
      m_st = en ? 1 : 0;
    end
    exp_state = m_st;
    exp_chk = 1;
  endtask
  initial forever begin
    exp_t e;
    @(posedge CLK);
    cyc++;
    #1;
    if (exp_chk) begin
      chk("state", 32'(O_STATE), 32'(exp_state));
      chk("valid_vs_gnt", 32'(O_VALID), 32'(|O_GNT));
    end
    if (O_VALID) begin
      obs_g.push_back(O_GNT);
      obs_d.push_back(O_DATA);
      if (sb.size() == 0) begin
        tot_n++;
        $display("FAIL unexpected_grant: got gnt=%b want none (cycle %0d)", O_GNT, cyc);
      end else begin
        e = sb.pop_front();
        chk("grant_cycle", cyc, e.cyc);
        chk("gnt", 32'(O_GNT), 32'(e.gnt));
        chk("data", 32'(O_DATA), 32'(e.data));
        chk("cnt16", 32'(O_WORD_CNT), e.cnt);
        chk("cnt4", 32'(cnt4), e.cnt4);
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      tot_n++;
      $display("FAIL missing_grant: got none want gnt=%b (cycle %0d)", sb[0].gnt, cyc);
      void'(sb.pop_front());
    end
  end
  task automatic settle();
    @(posedge CLK);
    #2;
  endtask
  initial begin
    logic [7:0] p2 [6];
    logic [3:0] p3g [5];
    logic [7:0] p3d [5];
    p2 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    p3g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    p3d = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    tick(1, 0, 0, 8'h00, 4'hF);
    tick(1, 0, 0, 8'h00, 4'hF);
    settle();
    chk("rst_gnt", 32'(O_GNT), 0);
    chk("rst_valid", 32'(O_VALID), 0);
    chk("rst_data", 32'(O_DATA), 0);
    chk("rst_cnt", 32'(O_WORD_CNT), 0);
    chk("rst_state", 32'(O_STATE), 0);
    repeat (5) tick(0, 0, 0, 8'h00, 4'hF);
    obs_d.delete(); obs_g.delete();
    repeat (14) tick(0, 1, 0, 8'h00, 4'b0001);
    settle();
    chk("single_req_count", 32'(obs_d.size() >= 6), 1);
    for (int i = 0; i < 6 && i < obs_d.size(); i++) begin
      chk("single_req_data", 32'(obs_d[i]), 32'(p2[i]));
      chk("single_req_gnt", 32'(obs_g[i]), 32'h1);
    end
    tick(1, 0, 0, 8'h00, 4'h0);
    obs_d.delete(); obs_g.delete();
    repeat (7) tick(0, 1, 0, 8'h00, 4'hF);
    settle();
    chk("all_req_count", 32'(obs_d.size() >= 5), 1);
    for (int i = 0; i < 5 && i < obs_d.size(); i++) begin
      chk("all_req_gnt", 32'(obs_g[i]), 32'(p3g[i]));
      chk("all_req_data", 32'(obs_d[i]), 32'(p3d[i]));
    end
    tick(0, 1, 1, 8'h00, 4'hF);
    settle();
    chk("zero_seed_state", 32'(O_STATE), 2);
    chk("zero_seed_valid", 32'(O_VALID), 0);
    chk("zero_seed_cnt", 32'(O_WORD_CNT), 0);
    obs_d.delete(); obs_g.delete();
    repeat (3) tick(0, 1, 0, 8'h00, 4'hF);
    settle();
    chk("zero_seed_word", obs_d.size() > 0 ? 32'(obs_d[0]) : 32'hDEAD, 32'h01);
    tick(0, 1, 1, 8'h5A, 4'b0010);
    obs_d.delete(); obs_g.delete();
    repeat (520) tick(0, 1, 0, 8'h00, 4'b0010);
    settle();
    chk("seed5a_count", 32'(obs_d.size() >= 256), 1);
    chk("seed5a_first", obs_d.size() > 0 ? 32'(obs_d[0]) : 32'hDEAD, 32'h5A);
    chk("seed5a_wrap", obs_d.size() > 255 ? 32'(obs_d[255]) : 32'hDEAD, 32'h5A);
    tick(1, 0, 0, 8'h00, 4'h0);
    repeat (22) tick(0, 1, 0, 8'h00, 4'hF);
    settle();
    chk("cnt4_saturated", 32'(cnt4), 32'hF);
    obs_d.delete(); obs_g.delete();
    repeat (6) tick(0, 0, 0, 8'h00, 4'hF);
    settle();
    chk("en_drop_no_grant", obs_d.size(), 0);
    for (int i = 0; i < 1500; i++)
      tick($urandom_range(199) == 0, $urandom_range(7) != 0, $urandom_range(39) == 0,
           $urandom_range(3) == 0 ? 8'h00 : 8'($urandom), 4'($urandom));
    repeat (4) tick(0, 0, 0, 8'h00, 4'h0);
    settle();
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
